// File: rtl/controller_pkg.sv
// Shared types for the accumulator CPU sequencer: opcode and state
// encodings plus the packed control-strobe bundle.
package controller_pkg;

    localparam int unsigned OPCODE_W = 3;
    localparam int unsigned STATE_W  = 4;

    // Instruction opcodes as held in the IR
    typedef enum logic [OPCODE_W-1:0] {
        HLT = 3'd0,
        SKZ = 3'd1,
        ADD = 3'd2,
        AND = 3'd3,
        XOR = 3'd4,
        LDA = 3'd5,
        STO = 3'd6,
        JMP = 3'd7
    } opcode_t;

    // Sequencer states; nine legal values in a 4-bit encoding
    typedef enum logic [STATE_W-1:0] {
        INST_ADDR  = 4'd0,
        INST_FETCH = 4'd1,
        INST_LOAD  = 4'd2,
        IDLE       = 4'd3,
        OP_ADDR    = 4'd4,
        OP_FETCH   = 4'd5,
        ALU_OP     = 4'd6,
        STORE      = 4'd7,
        HALTED     = 4'd8
    } state_t;

    // Control strobes driven around the datapath
    typedef struct packed {
        logic mem_rd;
        logic mem_wr;
        logic load_ir;
        logic load_ac;
        logic inc_pc;
        logic load_pc;
        logic sel;
        logic halt;
    } ctrl_t;

    // Opcodes whose result is written into the accumulator
    function automatic logic is_aluop(input opcode_t op);
        return (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
    endfunction

endpackage

// File: rtl/controller.sv
// Instruction-sequencing FSM for the 8-bit accumulator CPU.
// Every instruction walks eight states; HLT parks the machine in HALTED
// until reset. Strobes are a combinational decode of state, opcode, zero.
//
// Ports:
//   clk      rising-edge clock
//   rst_     synchronous active-low reset
//   opcode   current IR opcode (used from OP_ADDR through STORE)
//   zero     accumulator-is-zero flag (used only in ALU_OP)
//   mem_rd   memory read enable
//   mem_wr   memory write enable
//   load_ir  IR load enable
//   load_ac  accumulator load enable
//   inc_pc   PC increment enable
//   load_pc  PC parallel-load enable
//   sel      address mux select (1 = PC, 0 = IR operand)
//   halt     processor halted
module controller
    import controller_pkg::*;
(
    input  logic    clk,
    input  logic    rst_,
    input  opcode_t opcode,
    input  logic    zero,
    output logic    mem_rd,
    output logic    mem_wr,
    output logic    load_ir,
    output logic    load_ac,
    output logic    inc_pc,
    output logic    load_pc,
    output logic    sel,
    output logic    halt
);

    state_t state;
    state_t state_next;
    ctrl_t  ctrl;
    logic   aluop;

    assign aluop = is_aluop(opcode);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_) begin
            state <= INST_ADDR;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and strobe decode
    always_comb begin
        state_next = state;
        ctrl       = '0;
        case (state)
            INST_ADDR: begin
                ctrl.sel   = 1'b1;
                state_next = INST_FETCH;
            end
            INST_FETCH: begin
                ctrl.sel    = 1'b1;
                ctrl.mem_rd = 1'b1;
                state_next  = INST_LOAD;
            end
            INST_LOAD: begin
                ctrl.sel     = 1'b1;
                ctrl.mem_rd  = 1'b1;
                ctrl.load_ir = 1'b1;
                state_next   = IDLE;
            end
            IDLE: begin
                ctrl.sel     = 1'b1;
                ctrl.mem_rd  = 1'b1;
                ctrl.load_ir = 1'b1;
                state_next   = OP_ADDR;
            end
            OP_ADDR: begin
                ctrl.inc_pc = 1'b1;
                ctrl.halt   = (opcode == HLT);
                state_next  = (opcode == HLT) ? HALTED : OP_FETCH;
            end
            OP_FETCH: begin
                ctrl.mem_rd = aluop;
                state_next  = ALU_OP;
            end
            ALU_OP: begin
                ctrl.mem_rd  = aluop;
                ctrl.load_ac = aluop;
                ctrl.inc_pc  = (opcode == SKZ) && zero;
                ctrl.load_pc = (opcode == JMP);
                state_next   = STORE;
            end
            STORE: begin
                // JMP raises both; the PC gives load priority
                ctrl.mem_rd  = aluop;
                ctrl.load_ac = aluop;
                ctrl.mem_wr  = (opcode == STO);
                ctrl.inc_pc  = (opcode == JMP);
                ctrl.load_pc = (opcode == JMP);
                state_next   = INST_ADDR;
            end
            HALTED: begin
                ctrl.halt  = 1'b1;
                state_next = HALTED;
            end
            default: begin
                // Illegal encodings drive nothing and recover next edge
                state_next = INST_ADDR;
            end
        endcase
    end

    assign mem_rd  = ctrl.mem_rd;
    assign mem_wr  = ctrl.mem_wr;
    assign load_ir = ctrl.load_ir;
    assign load_ac = ctrl.load_ac;
    assign inc_pc  = ctrl.inc_pc;
    assign load_pc = ctrl.load_pc;
    assign sel     = ctrl.sel;
    assign halt    = ctrl.halt;

endmodule

// File: tb/tb_controller.sv
// Randomized scoreboard bench for the accumulator CPU sequencer.
module tb_controller;
    import controller_pkg::*;

    logic    clk = 1'b0;
    logic    rst_ = 1'b0;
    opcode_t opcode = HLT;
    logic    zero = 1'b0;
    logic    mem_rd, mem_wr, load_ir, load_ac, inc_pc, load_pc, sel, halt;

    controller dut (
        .clk(clk), .rst_(rst_), .opcode(opcode), .zero(zero),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .load_ir(load_ir), .load_ac(load_ac),
        .inc_pc(inc_pc), .load_pc(load_pc), .sel(sel), .halt(halt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         valid;
        logic [7:0] outs;   // {mem_rd,mem_wr,load_ir,load_ac,inc_pc,load_pc,sel,halt}
        state_t     st;
        int         cyc;
    } exp_t;

    exp_t sbq[$];
    int checks = 0;
    int errors = 0;

    // Reference model: position within the instruction (1..8) and halted flag
    int      m_cyc   = 0;
    bit      m_halt  = 1'b0;
    bit      m_valid = 1'b0;
    logic    prev_rst = 1'b0;
    opcode_t prev_op  = HLT;

    state_t walk [8] = '{INST_ADDR, INST_FETCH, INST_LOAD, IDLE,
                         OP_ADDR, OP_FETCH, ALU_OP, STORE};

    function automatic logic [7:0] model_outs(input int c, input bit h,
                                              input opcode_t op, input logic z);
        logic a, rd, wr, ir, ac, ip, lp, s, hl;
        a  = (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
        if (h) return 8'b0000_0001;
        s  = (c <= 4);
        rd = (c >= 2 && c <= 4) || (c >= 6 && a);
        ir = (c == 3) || (c == 4);
        ac = (c >= 7) && a;
        ip = (c == 5) || (c == 7 && op == SKZ && z) || (c == 8 && op == JMP);
        lp = (c >= 7) && (op == JMP);
        wr = (c == 8) && (op == STO);
        hl = (c == 5) && (op == HLT);
        return {rd, wr, ir, ac, ip, lp, s, hl};
    endfunction

    // One clock: advance the model across the edge, drive new inputs, queue expectation
    task automatic step(input logic r, input opcode_t op, input logic z);
        exp_t e;
        @(posedge clk);
        #1;
        if (!prev_rst) begin
            m_cyc = 1; m_halt = 1'b0; m_valid = 1'b1;
        end else if (m_valid && !m_halt) begin
            if (m_cyc == 5 && prev_op == HLT) m_halt = 1'b1;
            else m_cyc = (m_cyc == 8) ? 1 : m_cyc + 1;
        end
        rst_ = r; opcode = op; zero = z;
        prev_rst = r; prev_op = op;
        e.valid = m_valid;
        e.outs  = model_outs(m_cyc, m_halt, op, z);
        e.st    = m_halt ? HALTED : walk[(m_cyc >= 1 && m_cyc <= 8) ? m_cyc - 1 : 0];
        e.cyc   = m_halt ? 0 : m_cyc;
        sbq.push_back(e);
    endtask

    function automatic opcode_t rand_op();
        return opcode_t'(3'($urandom_range(0, 7)));
    endfunction

    // Issue the first n cycles of an instruction; fetch cycles see junk opcodes
    task automatic instr_n(input opcode_t op, input logic zalu, input int n);
        for (int c = 1; c <= n; c++) begin
            step(1'b1, (c <= 4) ? rand_op() : op,
                 (c == 7) ? zalu : 1'($urandom_range(0, 1)));
        end
    endtask

    task automatic instr(input opcode_t op, input logic zalu);
        instr_n(op, zalu, 8);
    endtask

    task automatic halt_seq(input int park);
        instr_n(HLT, 1'b0, 5);
        for (int i = 0; i < park; i++) step(1'b1, rand_op(), 1'($urandom_range(0, 1)));
        step(1'b0, rand_op(), 1'($urandom_range(0, 1)));
    endtask

    // Monitor: pop one expectation per cycle, compare away from the active edge
    always @(negedge clk) begin
        exp_t e;
        logic [7:0] got;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            if (e.valid) begin
                got = {mem_rd, mem_wr, load_ir, load_ac, inc_pc, load_pc, sel, halt};
                checks++;
                if (got !== e.outs) begin
                    errors++;
                    $display("FAIL strobes cyc=%0d state=%s op=%s zero=%b got=%b exp=%b",
                             e.cyc, dut.state.name(), opcode.name(), zero, got, e.outs);
                end
                checks++;
                if (dut.state !== e.st) begin
                    errors++;
                    $display("FAIL state cyc=%0d got=%s exp=%s",
                             e.cyc, dut.state.name(), e.st.name());
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        opcode_t ops [5] = '{SKZ, ADD, AND, XOR, LDA};
        // Reset held for two edges
        step(1'b0, HLT, 1'b0);
        step(1'b0, HLT, 1'b0);
        // Directed instructions
        instr(ADD, 1'b0);
        instr(SKZ, 1'b1);
        instr(SKZ, 1'b0);
        instr(JMP, 1'b1);
        instr(STO, 1'b1);
        instr(LDA, 1'b1);
        // HLT parks, then a single reset edge restarts
        halt_seq(25);
        instr(XOR, 1'b0);
        // Reset during ALU_OP of STO aborts the store
        instr_n(STO, 1'b0, 6);
        step(1'b0, STO, 1'b0);
        instr(AND, 1'b1);
        // Random instruction stream
        for (int i = 0; i < 40; i++) begin
            int sel_op = int'($urandom_range(0, 7));
            if (sel_op == 6)      instr(STO, 1'($urandom_range(0, 1)));
            else if (sel_op == 7) instr(JMP, 1'($urandom_range(0, 1)));
            else if (sel_op == 5) instr(SKZ, 1'($urandom_range(0, 1)));
            else                  instr(ops[sel_op], 1'($urandom_range(0, 1)));
            if (i == 20) halt_seq(int'($urandom_range(20, 30)));
        end
        halt_seq(22);
        instr(ADD, 1'b1);
        repeat (2) @(posedge clk);
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got=%0d exp=0", sbq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/controller.md
# controller

Instruction-sequencing state machine for the 8-bit accumulator CPU. Drives the opcode-timed control strobes (memory read/write, IR load, accumulator load, PC increment/load, address select, halt) that move each instruction through fetch, operand fetch, `alu` execution and writeback. It consumes the IR opcode and the `alu` `zero` flag, and produces every enable around the datapath. Every instruction takes exactly eight clock cycles, except `HLT`, which parks the machine until reset.

## Interface
- No parameters. The opcode width is fixed by `opcode_t` (3 bits).
- `clk`  in  1  rising-edge clock.
- `rst_`  in  1  reset. One clock; reset is synchronous and active-low.
- `opcode`  in  `opcode_t`  current instruction from the IR. Sampled only in `OP_ADDR` through `STORE`.
- `zero`  in  1  accumulator-is-zero flag from `alu`.
- `mem_rd`  out  1  memory read enable.
- `mem_wr`  out  1  memory write enable.
- `load_ir`  out  1  IR load enable.
- `load_ac`  out  1  accumulator load enable, which captures the `alu` out.
- `inc_pc`  out  1  PC increment enable.
- `load_pc`  out  1  PC parallel-load enable (jump).
- `sel`  out  1  address mux select: 1 selects PC, 0 selects the IR operand.
- `halt`  out  1  processor halted.

## Operation
- **State register `state`** (`state_t`). Sequence is `INST_ADDR` → `INST_FETCH` → `INST_LOAD` → `IDLE` → `OP_ADDR` → `OP_FETCH` → `ALU_OP` → `STORE` → `INST_ADDR`.
- **Halt.** In `OP_ADDR` with opcode == `HLT`, the next state is `HALTED`. `HALTED` is absorbing and is left only by reset.
- **Output decode.** Outputs are a combinational decode of `state`, `opcode` and `zero`. All outputs not listed below are 0.
- **`ALUOP` term.** `ALUOP` = opcode ∈ {`ADD`, `AND`, `XOR`, `LDA`}.
- **Per-state outputs:**
  - `INST_ADDR`: `sel`=1.
  - `INST_FETCH`: `sel`=1, `mem_rd`=1.
  - `INST_LOAD`: `sel`=1, `mem_rd`=1, `load_ir`=1.
  - `IDLE`: `sel`=1, `mem_rd`=1, `load_ir`=1.
  - `OP_ADDR`: `inc_pc`=1, `halt`=(opcode==`HLT`).
  - `OP_FETCH`: `mem_rd`=`ALUOP`.
  - `ALU_OP`: `mem_rd`=`ALUOP`, `load_ac`=`ALUOP`, `inc_pc`=(opcode==`SKZ` && `zero`), `load_pc`=(opcode==`JMP`).
  - `STORE`: `mem_rd`=`ALUOP`, `load_ac`=`ALUOP`, `mem_wr`=(opcode==`STO`), `inc_pc`=(opcode==`JMP`), `load_pc`=(opcode==`JMP`).
  - `HALTED`: `halt`=1, all other outputs 0 (including `sel`).
- **No-effect opcodes.** `SKZ` with `zero`=0, and `STO`, assert no `load_ac`. `STO` asserts no `mem_rd` in `OP_FETCH` through `STORE`.
- **`zero` usage.** `zero` is used only in `ALU_OP`. Its value in every other state is ignored.
- **Illegal state encodings** (`state_t` has 9 legal values in 4 bits) recover to `INST_ADDR` on the next edge.

## Timing
- **Reset.** With `rst_`=0 at a rising edge, `state` becomes `INST_ADDR` after that edge. Outputs are then `sel`=1, all others 0. Reset mid-instruction, including from `HALTED`, aborts the instruction with no further `mem_wr`/`load_*` pulses.
- **Strobe length.** Each strobe is high for whole cycles only. Consumers sample on the rising edge that ends the state.
- **Instruction latency.** An instruction occupies 8 cycles from `INST_ADDR` to the next `INST_ADDR`.
- **`HLT` latency.** `halt` rises in the cycle of `OP_ADDR` (cycle 5) and stays 1 from `HALTED` onward.
- **PC increments.**
  - Normal: `inc_pc` pulses once per instruction, in `OP_ADDR`.
  - `SKZ` taken: a second pulse in `ALU_OP`.
  - `JMP`: `inc_pc` and `load_pc` both high in `STORE`, and load has priority in the PC. `load_pc` is also high in `ALU_OP`.
- **`zero` timing.** `zero` must be stable by the `ALU_OP` rising edge. It reflects the accumulator from the previous instruction.

## Structure
- **`typedefs` package additions:**
  - `state_t`: enum logic [3:0] {`INST_ADDR`, `INST_FETCH`, `INST_LOAD`, `IDLE`, `OP_ADDR`, `OP_FETCH`, `ALU_OP`, `STORE`, `HALTED`}.
  - Existing `opcode_t` reused: `HLT`=0, `SKZ`=1, `ADD`=2, `AND`=3, `XOR`=4, `LDA`=5, `STO`=6, `JMP`=7.
- **Implementation shape.** One `always_ff` for `state` and one `always_comb` for next-state and output decode. No sub-module; the decode is too small to split.
- **Bench checks.** The bench uses `state.name()` in messages and checks every output every cycle against an independent model.

## Test plan
- **Reset.** Hold `rst_`=0 for 2 cycles, then release → `state`=`INST_ADDR`, `sel`=1, all else 0. The 8-cycle walk `INST_ADDR`..`STORE` follows with `load_ir` high in exactly cycles 3–4.
- **`ADD`.** opcode=`ADD`, `zero`=0 → `mem_rd`=1 in cycles 2–4 and 6–8. `load_ac`=1 in cycles 7–8. `inc_pc` only in cycle 5. `mem_wr`, `load_pc` never high.
- **`SKZ`.**
  - `zero`=1 → `inc_pc` high in cycles 5 and 7.
  - `zero`=0 → `inc_pc` high only in cycle 5.
  - Neither case asserts `load_ac`.
- **`JMP` and `STO`.**
  - opcode=`JMP` → `load_pc`=1 in cycles 7–8, `inc_pc`=1 in cycles 5 and 8.
  - opcode=`STO` → `mem_wr`=1 only in cycle 8, `mem_rd`=0 in cycles 6–8.
- **`HLT`.** opcode=`HLT` → `halt`=1 from cycle 5. The machine stays in `HALTED` for 20+ cycles with every other output 0. `rst_`=0 for one edge returns it to `INST_ADDR`.
- **Reset mid-op.** Assert `rst_`=0 during `ALU_OP` of an `STO` instruction → no `mem_wr` pulse. After release the machine restarts cleanly at `INST_ADDR`.
